// File: rtl/mont_domain_conv_if.sv
// Handshake bundle for mont_domain_conv.
//   Input side : in_valid/in_ready handshake carrying op, flag_384 (1: 384-bit, 0: 256-bit mode)
//                and dir (0: to-Montgomery, 1: from-Montgomery).
//   Output side: out_valid/out_ready handshake carrying result and err (operand out of range).
// master drives operands and out_ready; slave is the converter.
interface mont_domain_conv_if;
    logic         flag_384;
    logic         dir;
    logic         in_valid;
    logic         in_ready;
    logic [383:0] op;
    logic         out_valid;
    logic         out_ready;
    logic [383:0] result;
    logic         err;

    modport master (
        output flag_384, dir, in_valid, op, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  flag_384, dir, in_valid, op, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/mont_domain_conv.sv
// Bit-serial converter between the normal and Montgomery domains.
//   to-Mont  : result = op * R mod M
//   from-Mont: result = op * R^-1 mod M
// with R = 2^256 / M = M_256 (flag_384=0) or R = 2^384 / M = M_384 (flag_384=1).
// One shift plus one conditional subtract (to-Mont) or conditional add-and-halve (from-Mont)
// per cycle, N = 256 or 384 cycles per conversion. Operands >= M are rejected with err=1.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mont_domain_conv_if.slave (input and output handshakes)
module mont_domain_conv #(
    parameter logic [255:0] M_256 =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001,
    parameter logic [383:0] M_384 =
        384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
) (
    input  logic                clk,
    input  logic                rst_n,
    mont_domain_conv_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [383:0] acc_q, acc_d;
    logic [8:0]   cnt_q, cnt_d;
    logic         mode_q, mode_d;
    logic         dir_q, dir_d;
    logic         err_q, err_d;

    // Input range check: in 256-bit mode any set bit above 255 already means op >= M.
    logic op_ok;
    always_comb begin
        if (bus.flag_384) begin
            op_ok = (bus.op < M_384);
        end else begin
            op_ok = (bus.op[383:256] == 128'd0) && (bus.op[255:0] < M_256);
        end
    end

    // Shared step datapath. One 386-bit adder serves both directions:
    //   to-Mont  : sum = (acc<<1) + ~M + 1 = (acc<<1) - M, carry-out set means no borrow (t >= M)
    //   from-Mont: sum = acc + (acc[0] ? M : 0), then halve
    logic [384:0] m_sel;
    logic [384:0] add_a;
    logic [384:0] add_b;
    logic         add_cin;
    logic [385:0] sum;
    logic [383:0] step_val;

    always_comb begin
        m_sel   = mode_q ? {1'b0, M_384} : {129'd0, M_256};
        add_a   = dir_q ? {1'b0, acc_q} : {acc_q, 1'b0};
        add_b   = dir_q ? (acc_q[0] ? m_sel : 385'd0) : ~m_sel;
        add_cin = ~dir_q;
        sum     = {1'b0, add_a} + {1'b0, add_b} + {385'd0, add_cin};
        if (dir_q) begin
            step_val = sum[384:1];
        end else if (sum[385]) begin
            // t - M < M < 2^384, so the low 384 bits hold the full difference
            step_val = sum[383:0];
        end else begin
            // t < M < 2^384, so bit 384 of the shifted value is zero
            step_val = add_a[383:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mode_d = bus.flag_384;
                    dir_d  = bus.dir;
                    if (op_ok) begin
                        acc_d   = bus.op;
                        cnt_d   = bus.flag_384 ? 9'd383 : 9'd255;
                        err_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        acc_d   = 384'd0;
                        cnt_d   = 9'd0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                acc_d = step_val;
                cnt_d = cnt_q - 9'd1;
                if (cnt_q == 9'd0) begin
                    cnt_d   = 9'd0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= 384'd0;
            cnt_q   <= 9'd0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // acc < M always holds, so in 256-bit mode the upper bits are already zero.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.result    = (state_q == StDone) ? acc_q : 384'd0;
        bus.err       = (state_q == StDone) && err_q;
    end

endmodule

// File: tb/tb_mont_domain_conv.sv
// Self-checking bench for mont_domain_conv: vector table, random conversions against a
// big-integer reference model, output stall and mid-run reset sequences.
module tb_mont_domain_conv;

    localparam logic [255:0] M256 =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
    localparam logic [383:0] M384 =
        384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    localparam logic [383:0] V384 =
        384'h15f65ec3fa80e4935c071a97a256ec6d77ce5853705257455f48985753c758baebf4000bc40c0002760900000002fffd;
    localparam logic [383:0] V256 =
        384'h1824b159acc5056f998c4fefecbc4ff55884b7fa0003480200000001fffffffe;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mont_domain_conv_if bus ();

    mont_domain_conv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         f;
        logic         d;
        logic [383:0] op;
        logic [383:0] res;
        logic         err;
        int           lat;
    } vec_t;

    vec_t tbl[11];

    // ---------------- reference model ----------------
    function automatic logic [383:0] mod_of(input logic f);
        return f ? M384 : {128'd0, M256};
    endfunction

    // a * 2^N mod M by plain wide arithmetic
    function automatic logic [383:0] to_mont(input logic f, input logic [383:0] a);
        logic [767:0] w;
        w = {384'd0, a} << (f ? 384 : 256);
        w = w % {384'd0, mod_of(f)};
        return w[383:0];
    endfunction

    function automatic logic in_range(input logic f, input logic [383:0] a);
        logic [383:0] hi;
        hi = a >> 256;
        if (f) return a < M384;
        return (hi == 384'd0) && (a < {128'd0, M256});
    endfunction

    function automatic logic [383:0] rand_below(input logic f);
        logic [383:0] a;
        for (int w = 0; w < 12; w++) a[w*32 +: 32] = $urandom();
        return a % mod_of(f);
    endfunction

    // ---------------- check / drive helpers ----------------
    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents an operand (caller is #1 after an edge, DUT in IDLE) and returns #1 after the
    // accept edge; inputs are then scrambled to show they are ignored outside IDLE.
    task automatic send(input logic f, input logic d, input logic [383:0] a);
        bus.flag_384 = f;
        bus.dir      = d;
        bus.op       = a;
        bus.in_valid = 1'b1;
        chk("in_ready_before_accept", {383'd0, bus.in_ready}, 384'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flag_384 = ~f;
        bus.dir      = ~d;
        bus.op       = {$urandom(), $urandom(), $urandom()};
    endtask

    // Edges counted after the accept edge until out_valid; 0 means visible in the cycle
    // straight after the handshake.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_op(input logic f, input logic d, input logic [383:0] a,
                         output logic [383:0] res, output logic err, output int lat);
        send(f, d, a);
        wait_out(lat);
        res = bus.result;
        err = bus.err;
        take();
    endtask

    logic [383:0] r_res;
    logic [383:0] r2_res;
    logic         r_err;
    int           r_lat;

    initial begin
        errors = 0;
        checks = 0;

        tbl[0]  = '{1'b1, 1'b0, 384'd1, V384, 1'b0, 384};
        tbl[1]  = '{1'b0, 1'b0, 384'd1, V256, 1'b0, 256};
        tbl[2]  = '{1'b1, 1'b1, V384, 384'd1, 1'b0, 384};
        tbl[3]  = '{1'b0, 1'b1, V256, 384'd1, 1'b0, 256};
        tbl[4]  = '{1'b1, 1'b0, M384, 384'd0, 1'b1, 0};
        tbl[5]  = '{1'b0, 1'b0, 384'd1 << 256, 384'd0, 1'b1, 0};
        tbl[6]  = '{1'b0, 1'b1, {128'd0, M256}, 384'd0, 1'b1, 0};
        tbl[7]  = '{1'b1, 1'b0, 384'd0, 384'd0, 1'b0, 384};
        tbl[8]  = '{1'b1, 1'b1, 384'd0, 384'd0, 1'b0, 384};
        tbl[9]  = '{1'b0, 1'b0, 384'd0, 384'd0, 1'b0, 256};
        tbl[10] = '{1'b0, 1'b1, 384'd0, 384'd0, 1'b0, 256};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flag_384  = 1'b0;
        bus.dir       = 1'b0;
        bus.op        = 384'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", {383'd0, bus.out_valid}, 384'd0);
        chk("reset_err", {383'd0, bus.err}, 384'd0);
        chk("reset_result", bus.result, 384'd0);
        chk("reset_in_ready", {383'd0, bus.in_ready}, 384'd1);
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].f, tbl[i].d, tbl[i].op, r_res, r_err, r_lat);
            chk($sformatf("tbl%0d_result", i), r_res, tbl[i].res);
            chk($sformatf("tbl%0d_err", i), {383'd0, r_err}, {383'd0, tbl[i].err});
            chk($sformatf("tbl%0d_latency", i), 384'(r_lat), 384'(tbl[i].lat));
            chk($sformatf("tbl%0d_idle_after", i), {383'd0, bus.in_ready}, 384'd1);
        end

        // Random conversions in both modes
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) begin
                logic         f;
                logic [383:0] a;
                logic [383:0] b;
                f = (m == 1);
                a = rand_below(f);
                do_op(f, 1'b0, a, r_res, r_err, r_lat);
                chk($sformatf("rnd_fwd_m%0d_%0d", m, k), r_res, to_mont(f, a));
                chk($sformatf("rnd_fwd_lat_m%0d_%0d", m, k), 384'(r_lat), f ? 384'd384 : 384'd256);
                do_op(f, 1'b1, r_res, r2_res, r_err, r_lat);
                chk($sformatf("rnd_trip_m%0d_%0d", m, k), r2_res, a);
                chk($sformatf("rnd_trip_err_m%0d_%0d", m, k), {383'd0, r_err}, 384'd0);
                // from-Mont of an arbitrary value y: result x must satisfy x*R mod M == y
                b = rand_below(f);
                do_op(f, 1'b1, b, r_res, r_err, r_lat);
                chk($sformatf("rnd_inv_m%0d_%0d", m, k), to_mont(f, r_res), b);
                chk($sformatf("rnd_inv_range_m%0d_%0d", m, k),
                    {383'd0, in_range(f, r_res)}, 384'd1);
            end
        end

        // Output stall: hold out_ready low with another operand pending
        begin
            logic [383:0] a;
            logic [383:0] held;
            a = rand_below(1'b0);
            send(1'b0, 1'b0, a);
            wait_out(r_lat);
            held = bus.result;
            chk("stall_first_result", held, to_mont(1'b0, a));
            bus.flag_384 = 1'b1;
            bus.dir      = 1'b0;
            bus.op       = 384'd1;
            bus.in_valid = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                chk($sformatf("stall_valid_%0d", c), {383'd0, bus.out_valid}, 384'd1);
                chk($sformatf("stall_result_%0d", c), bus.result, held);
                chk($sformatf("stall_err_%0d", c), {383'd0, bus.err}, 384'd0);
                chk($sformatf("stall_in_ready_%0d", c), {383'd0, bus.in_ready}, 384'd0);
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            chk("stall_idle_valid", {383'd0, bus.out_valid}, 384'd0);
            chk("stall_idle_ready", {383'd0, bus.in_ready}, 384'd1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk("stall_pending_accepted", {383'd0, bus.in_ready}, 384'd0);
            wait_out(r_lat);
            chk("stall_second_result", bus.result, V384);
            chk("stall_second_lat", 384'(r_lat), 384'd384);
            take();
        end

        // Reset at step 100 of a 384-bit run
        send(1'b1, 1'b0, 384'd5);
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {383'd0, bus.out_valid}, 384'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready", {383'd0, bus.in_ready}, 384'd1);
        chk("rst_mid_valid_after", {383'd0, bus.out_valid}, 384'd0);
        @(posedge clk);
        #1;
        do_op(1'b1, 1'b0, 384'd1, r_res, r_err, r_lat);
        chk("rst_after_result", r_res, V384);
        chk("rst_after_lat", 384'(r_lat), 384'd384);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
